// File: rtl/mem_arbiter_if.sv
// CPU/memory bundle for mem_arbiter; the boot-loader port exists
// only when MEMARB_LOADER_EN is defined.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_instr;
  logic          if_valid;
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;
`ifdef MEMARB_LOADER_EN
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
`endif

  modport slave (
    input  if_req, if_addr,
    input  d_rd, d_wr, d_addr, d_wdata,
    input  mem_rdata,
`ifdef MEMARB_LOADER_EN
    input  ld_req, ld_addr, ld_wdata,
    output ld_ack,
`endif
    output if_instr, if_valid,
    output d_rdata, d_done, stall,
    output mem_addr, mem_wdata,
    output mem_rd, mem_wr
  );

  modport master (
    output if_req, if_addr,
    output d_rd, d_wr, d_addr, d_wdata,
    output mem_rdata,
`ifdef MEMARB_LOADER_EN
    output ld_req, ld_addr, ld_wdata,
    input  ld_ack,
`endif
    input  if_instr, if_valid,
    input  d_rdata, d_done, stall,
    input  mem_addr, mem_wdata,
    input  mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one multi-cycle single-port memory.
// Define MEMARB_LOADER_EN to add a top-priority write-only loader.
module mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ACCESS, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OWN_IF, OWN_D, OWN_LD
  } owner_e;

  state_e        r_state;
  owner_e        r_owner;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_starve;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic [DW-1:0] r_if_instr;
  logic          r_if_valid;
  logic [DW-1:0] r_d_rdata;
  logic          r_d_done;
`ifdef MEMARB_LOADER_EN
  logic          r_ld_ack;
`endif

  logic w_d_req;
  logic w_starved;
  logic w_gnt_ld;
  logic w_gnt_d;
  logic w_gnt_if;
  logic w_stall;

  always_comb begin
    w_d_req   = bus.d_rd | bus.d_wr;
    w_starved = bus.if_req &
      (r_starve >= SW'(STARVE_LIMIT));
    w_gnt_ld  = 1'b0;
`ifdef MEMARB_LOADER_EN
    w_gnt_ld  = bus.ld_req;
`endif
    w_gnt_d   = ~w_gnt_ld & w_d_req & ~w_starved;
    w_gnt_if  = ~w_gnt_ld & ~w_gnt_d & bus.if_req;
  end

  always_comb begin
    w_stall = (bus.if_req | w_d_req) &
      ~(r_if_valid | r_d_done);
`ifdef MEMARB_LOADER_EN
    w_stall = w_stall | bus.ld_req;
`endif
    w_stall = w_stall & reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_IF;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_if_instr  <= '0;
      r_if_valid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_done    <= 1'b0;
`ifdef MEMARB_LOADER_EN
      r_ld_ack    <= 1'b0;
`endif
    end else begin
      r_if_valid <= 1'b0;
      r_d_done   <= 1'b0;
`ifdef MEMARB_LOADER_EN
      r_ld_ack   <= 1'b0;
`endif
      if (!bus.if_req)
        r_starve <= '0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= CW'(WAIT_CYCLES - 1);
          unique case (1'b1)
`ifdef MEMARB_LOADER_EN
            w_gnt_ld: begin
              r_owner     <= OWN_LD;
              r_mem_addr  <= bus.ld_addr;
              r_mem_wdata <= bus.ld_wdata;
              r_mem_wr    <= 1'b1;
              r_state     <= S_ACCESS;
            end
`endif
            w_gnt_d: begin
              r_owner     <= OWN_D;
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
              // write wins when both ops are requested
              r_mem_wr    <= bus.d_wr;
              r_mem_rd    <= ~bus.d_wr;
              r_state     <= S_ACCESS;
              if (bus.if_req &&
                  r_starve < SW'(STARVE_LIMIT))
                r_starve <= r_starve + 1'b1;
            end
            w_gnt_if: begin
              r_owner    <= OWN_IF;
              r_mem_addr <= bus.if_addr;
              r_mem_rd   <= 1'b1;
              r_state    <= S_ACCESS;
              r_starve   <= '0;
            end
            default: ;
          endcase
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_state  <= S_DONE;
            unique case (r_owner)
              OWN_IF: begin
                r_if_valid <= 1'b1;
                r_if_instr <= bus.mem_rdata;
              end
              OWN_D: begin
                r_d_done <= 1'b1;
                if (!r_mem_wr)
                  r_d_rdata <= bus.mem_rdata;
              end
              default: begin
`ifdef MEMARB_LOADER_EN
                r_ld_ack <= 1'b1;
`endif
              end
            endcase
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.if_instr  = r_if_instr;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.stall     = w_stall;
`ifdef MEMARB_LOADER_EN
  assign bus.ld_ack    = r_ld_ack;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WAIT_CYCLES=2, STARVE_LIMIT=4).
// Loader ordering steps are built when MEMARB_LOADER_EN is defined.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(
    .AW(16), .DW(16),
    .WAIT_CYCLES(2), .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  int  ndone;
  int  nfetch;
  logic tmo;
  logic saw_done;
`ifdef MEMARB_LOADER_EN
  int  seq[$];
  int  npulse;
`endif

  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_rd      = 1'b0;
    bus.d_wr      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
`ifdef MEMARB_LOADER_EN
    bus.ld_req    = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_wdata  = '0;
`endif

    // reset values
    tick();
    tick();
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_d_done", bus.d_done, 0);
    chk("rst_stall", bus.stall, 0);
    reset = 1'b1;
    tick();

    // single fetch
    bus.if_req    = 1'b1;
    bus.if_addr   = 16'h0010;
    bus.mem_rdata = 16'h1234;
    #1;
    chk("f_stall_c0", bus.stall, 1);
    tick();
    chk("f_mem_rd_c1", bus.mem_rd, 1);
    chk("f_mem_addr", bus.mem_addr, 16'h0010);
    chk("f_mem_wr_c1", bus.mem_wr, 0);
    chk("f_stall_c1", bus.stall, 1);
    tick();
    chk("f_mem_rd_c2", bus.mem_rd, 1);
    chk("f_valid_c2", bus.if_valid, 0);
    chk("f_stall_c2", bus.stall, 1);
    tick();
    chk("f_valid_c3", bus.if_valid, 1);
    chk("f_instr", bus.if_instr, 16'h1234);
    chk("f_mem_rd_c3", bus.mem_rd, 0);
    chk("f_stall_c3", bus.stall, 0);
    bus.if_req = 1'b0;
    tick();
    chk("f_valid_c4", bus.if_valid, 0);

    // collision: data first, fetch done at cycle 7
    bus.if_req    = 1'b1;
    bus.if_addr   = 16'h0020;
    bus.d_rd      = 1'b1;
    bus.d_addr    = 16'h0200;
    bus.mem_rdata = 16'hAAAA;
    tick();
    chk("c_mem_addr_d", bus.mem_addr, 16'h0200);
    chk("c_mem_rd_d", bus.mem_rd, 1);
    tick();
    tick();
    chk("c_d_done", bus.d_done, 1);
    chk("c_d_rdata", bus.d_rdata, 16'hAAAA);
    chk("c_if_valid_c3", bus.if_valid, 0);
    bus.d_rd      = 1'b0;
    bus.mem_rdata = 16'h5555;
    tick();
    chk("c_stall_c4", bus.stall, 1);
    tick();
    chk("c_mem_addr_f", bus.mem_addr, 16'h0020);
    tick();
    chk("c_if_valid_c6", bus.if_valid, 0);
    tick();
    chk("c_if_valid_c7", bus.if_valid, 1);
    chk("c_if_instr", bus.if_instr, 16'h5555);
    chk("c_d_rdata_hold", bus.d_rdata, 16'hAAAA);
    bus.if_req = 1'b0;
    tick();

    // read+write: write wins
    bus.d_rd      = 1'b1;
    bus.d_wr      = 1'b1;
    bus.d_addr    = 16'h0005;
    bus.d_wdata   = 16'hBEEF;
    bus.mem_rdata = 16'h7777;
    tick();
    chk("rw_mem_wr", bus.mem_wr, 1);
    chk("rw_mem_rd", bus.mem_rd, 0);
    chk("rw_mem_addr", bus.mem_addr, 16'h0005);
    chk("rw_mem_wdata", bus.mem_wdata, 16'hBEEF);
    tick();
    tick();
    chk("rw_d_done", bus.d_done, 1);
    chk("rw_d_rdata", bus.d_rdata, 16'hAAAA);
    chk("rw_mem_wr_done", bus.mem_wr, 0);
    bus.d_rd = 1'b0;
    bus.d_wr = 1'b0;
    tick();

    // starvation: 4 data grants per fetch grant
    bus.if_req    = 1'b1;
    bus.if_addr   = 16'h0030;
    bus.d_rd      = 1'b1;
    bus.d_addr    = 16'h0040;
    bus.mem_rdata = 16'h9999;
    ndone  = 0;
    nfetch = 0;
    tmo    = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.d_done) ndone++;
      if (bus.if_valid) begin
        chk("starve_dgrants", ndone, 4);
        chk("starve_instr", bus.if_instr, 16'h9999);
        ndone = 0;
        nfetch++;
        if (nfetch == 2) begin
          tmo = 1'b0;
          break;
        end
      end
    end
    chk("starve_timeout", tmo, 0);
    bus.if_req = 1'b0;
    bus.d_rd   = 1'b0;
    tick();
    tick();

    // async reset mid-write
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h0077;
    bus.d_wdata = 16'h1111;
    tick();
    chk("ar_mem_wr_pre", bus.mem_wr, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_mem_wr", bus.mem_wr, 0);
    chk("ar_mem_addr", bus.mem_addr, 0);
    chk("ar_mem_wdata", bus.mem_wdata, 0);
    chk("ar_stall", bus.stall, 0);
    chk("ar_d_rdata", bus.d_rdata, 0);
    chk("ar_if_instr", bus.if_instr, 0);
    bus.d_wr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.d_done) saw_done = 1'b1;
    end
    chk("ar_no_done", saw_done, 0);

`ifdef MEMARB_LOADER_EN
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 16'h0100;
    bus.ld_wdata = 16'hCAFE;
    bus.d_wr     = 1'b1;
    bus.d_addr   = 16'h0101;
    bus.if_req   = 1'b1;
    bus.if_addr  = 16'h0102;
    npulse = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.ld_ack) begin
        seq.push_back(1);
        bus.ld_req = 1'b0;
      end
      if (bus.d_done) begin
        seq.push_back(2);
        bus.d_wr = 1'b0;
      end
      if (bus.if_valid) begin
        seq.push_back(3);
        bus.if_req = 1'b0;
      end
      if (seq.size() == npulse)
        chk("ld_stall", bus.stall, 1);
      npulse = seq.size();
      if (npulse == 3) break;
    end
    chk("ld_npulse", npulse, 3);
    if (npulse == 3) begin
      chk("ld_first", seq[0], 1);
      chk("ld_second", seq[1], 2);
      chk("ld_third", seq[2], 3);
    end
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
